// File: rtl/io_bus_master_if.sv
// Memory-mapped IO port bus: strobes, 2-bit address, write data out,
// combinational read data back from the responder.
interface io_bus_master_if;
    logic        pRead;
    logic        pWrite;
    logic [1:0]  addr;
    logic [11:0] pWriteData;
    logic [31:0] pReadData;

    modport master (
        output pRead,
        output pWrite,
        output addr,
        output pWriteData,
        input  pReadData
    );

    modport slave (
        input  pRead,
        input  pWrite,
        input  addr,
        input  pWriteData,
        output pReadData
    );
endinterface

// File: rtl/io_bus_master.sv
// IO port initiator: poll switches, read two bytes, ALU, write LEDs, poll ack.
// Optional poll timeout enabled by defining IO_MASTER_TIMEOUT_EN.
module io_bus_master #(
    parameter int POLL_LIMIT = 1024,
    parameter int CNT_W      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] result,
    io_bus_master_if.master bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_IN  = 3'd1;
    localparam logic [2:0] S_RD_HI    = 3'd2;
    localparam logic [2:0] S_RD_LO    = 3'd3;
    localparam logic [2:0] S_CALC     = 3'd4;
    localparam logic [2:0] S_WR_LED   = 3'd5;
    localparam logic [2:0] S_WAIT_ACK = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [1:0] A_STAT = 2'b00;
    localparam logic [1:0] A_LED  = 2'b01;
    localparam logic [1:0] A_SWLO = 2'b10;
    localparam logic [1:0] A_SWHI = 2'b11;

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [11:0] res_q, res_d;
    logic [11:0] alu;
    logic        accept;
    logic        poll_clr;
    logic        poll_inc;
    logic        tmo;
    logic        timeout;
    logic        unused_rd;

    assign unused_rd = ^bus.pReadData[31:8];
    assign accept    = (state_q == S_IDLE) && start;

    always_comb begin
        unique case (op_q)
            2'b00:   alu = {3'b000, {1'b0, a_q} + {1'b0, b_q}};
            2'b01:   alu = {4'h0, a_q} - {4'h0, b_q};
            2'b10:   alu = {4'h0, a_q} * {4'h0, b_q};
            default: alu = {a_q[3:0], b_q};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        poll_clr = 1'b0;
        poll_inc = 1'b0;
        tmo      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    poll_clr = 1'b1;
                    state_d  = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (bus.pReadData[1]) begin
                    state_d = S_RD_HI;
                end else if (timeout) begin
                    tmo     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    poll_inc = 1'b1;
                end
            end
            S_RD_HI: begin
                a_d     = bus.pReadData[7:0];
                state_d = S_RD_LO;
            end
            S_RD_LO: begin
                b_d     = bus.pReadData[7:0];
                state_d = S_CALC;
            end
            S_CALC: begin
                res_d    = alu;
                poll_clr = 1'b1;
                state_d  = S_WR_LED;
            end
            S_WR_LED: state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (bus.pReadData[0]) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    tmo     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    poll_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            res_q   <= 12'h000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

`ifdef IO_MASTER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign timeout = (cnt_q == CNT_MAX);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (poll_clr)
                cnt_q <= '0;
            else if (poll_inc)
                cnt_q <= cnt_q + 1'b1;
            // err is sticky across DONE/IDLE until a new op is accepted
            if (accept)
                err_q <= 1'b0;
            else if (tmo)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign err        = 1'b0;
    assign unused_cfg = ^{accept, poll_clr, poll_inc, tmo,
                          1'(POLL_LIMIT), 1'(CNT_W)};
`endif

    // Bus strobes are a pure function of state; idle bus is all-zero
    always_comb begin
        bus.pRead      = 1'b0;
        bus.pWrite     = 1'b0;
        bus.addr       = A_STAT;
        bus.pWriteData = 12'h000;
        unique case (state_q)
            S_WAIT_IN,
            S_WAIT_ACK: bus.pRead = 1'b1;
            S_RD_HI: begin
                bus.pRead = 1'b1;
                bus.addr  = A_SWHI;
            end
            S_RD_LO: begin
                bus.pRead = 1'b1;
                bus.addr  = A_SWLO;
            end
            S_WR_LED: begin
                bus.pWrite     = 1'b1;
                bus.addr       = A_LED;
                bus.pWriteData = res_q;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = res_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Randomized bench for io_bus_master against a transaction-level model.
// Build with IO_MASTER_TIMEOUT_EN to also cover the poll timeout.
module tb_io_bus_master;

`ifdef IO_MASTER_TIMEOUT_EN
    localparam int TB_LIMIT = 8;
    localparam bit TMO      = 1'b1;
`else
    localparam int TB_LIMIT = 1024;
    localparam bit TMO      = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] result;

    io_bus_master_if bus ();

    io_bus_master #(
        .POLL_LIMIT(TB_LIMIT),
        .CNT_W     (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .result(result),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder: status bit 1 rises after in_need zero polls,
    // bit 0 rises after ack_need zero polls following the LED write.
    logic [15:0] sw;
    logic [23:0] junk;
    int          in_need;
    int          ack_need;
    int          in_polls  = 0;
    int          ack_polls = 0;
    bit          phase_ack = 1'b0;
    logic        in_bit;
    logic        ack_bit;

    assign in_bit  = phase_ack || (in_polls >= in_need);
    assign ack_bit = phase_ack && (ack_polls >= ack_need);

    always_comb begin
        bus.pReadData = {junk, 8'h00};
        case (bus.addr)
            2'd0: bus.pReadData[1:0] = {in_bit, ack_bit};
            2'd3: bus.pReadData[7:0] = sw[15:8];
            2'd2: bus.pReadData[7:0] = sw[7:0];
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (start && !busy) begin
            in_polls  <= 0;
            ack_polls <= 0;
            phase_ack <= 1'b0;
        end else if (bus.pWrite) begin
            phase_ack <= 1'b1;
            ack_polls <= 0;
        end else if (bus.pRead && bus.addr == 2'd0) begin
            if (!phase_ack && in_polls < in_need)
                in_polls <= in_polls + 1;
            if (phase_ack && ack_polls < ack_need)
                ack_polls <= ack_polls + 1;
        end
    end

    // Per-cycle bus trace while busy, plus bus invariants every cycle
    bit          rec = 1'b0;
    logic [16:0] trace[$];

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("rd_wr_excl", 32'(bus.pRead & bus.pWrite), 32'd0);
            if (!bus.pRead && !bus.pWrite)
                chk("idle_bus", 32'({bus.addr, bus.pWriteData}), 32'd0);
        end
        if (rec && busy)
            trace.push_back({done, bus.pRead, bus.pWrite,
                             bus.addr, bus.pWriteData});
        else if (!rec)
            trace.delete();
    end

    function automatic logic [11:0] ref_alu(int o, int a, int b);
        int r;
        case (o)
            0:       r = a + b;
            1:       r = a - b + 4096;
            2:       r = a * b;
            default: r = (a % 16) * 256 + b;
        endcase
        return 12'(r % 4096);
    endfunction

    function automatic logic [16:0] ev(bit d, bit r, bit w, int ad, int dat);
        return {d, r, w, 2'(ad), 12'(dat)};
    endfunction

    logic [11:0] exp_res = 12'h000;
    logic        exp_err = 1'b0;

    task automatic run_op(input logic [1:0] o, input logic [15:0] sw_v,
                          input int in_n, input int ack_n, input bit again);
        logic [16:0] exp_q[$];
        logic [11:0] v;
        int          lim;
        int          f0;
        bit          wr_seen = 1'b0;
        bit          pulsed  = 1'b0;
        bit          fin     = 1'b0;

        lim = TMO ? TB_LIMIT : 32'h3fff_ffff;
        v   = ref_alu(int'(o), int'(sw_v[15:8]), int'(sw_v[7:0]));
        exp_err = 1'b0;
        if (in_n >= lim) begin
            repeat (lim) exp_q.push_back(ev(0, 1, 0, 0, 0));
            exp_err = 1'b1;
        end else begin
            repeat (in_n + 1) exp_q.push_back(ev(0, 1, 0, 0, 0));
            exp_q.push_back(ev(0, 1, 0, 3, 0));
            exp_q.push_back(ev(0, 1, 0, 2, 0));
            exp_q.push_back(ev(0, 0, 0, 0, 0));
            exp_q.push_back(ev(0, 0, 1, 1, int'(v)));
            exp_res = v;
            if (ack_n >= lim) begin
                repeat (lim) exp_q.push_back(ev(0, 1, 0, 0, 0));
                exp_err = 1'b1;
            end else begin
                repeat (ack_n + 1) exp_q.push_back(ev(0, 1, 0, 0, 0));
            end
        end
        exp_q.push_back(ev(1, 0, 0, 0, 0));

        rec = 1'b0;
        @(negedge clk);
        sw       = sw_v;
        in_need  = in_n;
        ack_need = ack_n;
        junk     = 24'($urandom);
        rec      = 1'b1;
        op       = o;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3000 && !fin; i++) begin
            if (bus.pWrite)
                wr_seen = 1'b1;
            if (done) begin
                fin   = 1'b1;
                start = again;
            end else if (again && wr_seen && !bus.pWrite && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!fin)
                @(negedge clk);
        end
        if (!fin)
            chk("op_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("no_restart", 32'(busy), 32'd0);
        rec = 1'b0;
        chk("trace_len", 32'(trace.size()), 32'(exp_q.size()));
        f0 = n_fail;
        for (int i = 0; i < trace.size() && i < exp_q.size(); i++) begin
            chk($sformatf("trace[%0d]", i), 32'(trace[i]), 32'(exp_q[i]));
            if (n_fail != f0)
                break;
        end
        chk("result", 32'(result), 32'(exp_res));
        chk("err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        bit seen;

        reset    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        sw       = 16'h0000;
        junk     = 24'h0;
        in_need  = 0;
        ack_need = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", 32'({done, err, bus.pRead, bus.pWrite, bus.addr,
                             bus.pWriteData, result}), 32'd0);
        reset = 1'b1;

        run_op(2'b00, 16'h1234, 0, 2, 1'b0);
        run_op(2'b01, 16'h0102, 0, 1, 1'b0);
        run_op(2'b10, 16'hFFFF, 0, 0, 1'b0);
        run_op(2'b11, 16'hA5C3, 0, 3, 1'b0);
        run_op(2'b00, 16'h7F81, 50, 1, 1'b0);
        run_op(2'b10, 16'h3C0B, 0, 2, 1'b1);

        // Abort from WAIT_ACK, then a clean operation
        rec      = 1'b0;
        sw       = 16'h0303;
        in_need  = 0;
        ack_need = 40;
        op       = 2'b10;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.pWrite)
                seen = 1'b1;
        end
        chk("pre_rst_write", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_outs", 32'({done, err, bus.pRead, bus.pWrite, bus.addr,
                               bus.pWriteData, result}), 32'd0);
        reset   = 1'b1;
        exp_res = 12'h000;
        run_op(2'b01, 16'h1020, 1, 1, 1'b0);

`ifdef IO_MASTER_TIMEOUT_EN
        run_op(2'b00, 16'h1111, 1000, 0, 1'b0);
        run_op(2'b11, 16'h5A5A, 0, 1000, 1'b0);
        run_op(2'b00, 16'h0102, 0, 1, 1'b0);
`endif

        for (int k = 0; k < 24; k++)
            run_op(2'($urandom_range(0, 3)), 16'($urandom),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Hardware initiator for the 2-bit-address memory-mapped IO port protocol. Drives pRead/pWrite/addr/pWriteData and consumes pReadData.
- Per operation: polls the status port until a switch input is latched, then reads the high and low switch bytes. It combines them with a selectable ALU op and writes the 12-bit result to the LED data port. Finally it polls until the LED value is acknowledged as displayed.
- Replaces the CPU software loop for bring-up and self-test of the IO peripheral.

Parameters:
- POLL_LIMIT, 1024: poll cycles allowed per wait state before timeout (used only with TIMEOUT_EN).
- CNT_W, 10: poll counter width. Must satisfy 2^CNT_W >= POLL_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (asserted = 0).
- start  in  1  pulse to begin one operation; sampled only in IDLE.
- op  in  2  operation select, latched on accepted start. 00 = a+b, 01 = a-b, 10 = a*b, 11 = {a[3:0],b}.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  poll timeout flag (TIMEOUT_EN only, else constant 0).
- result  out  12  last value written to the LED port.
- pRead  out  1  bus read strobe.
- pWrite  out  1  bus write strobe.
- addr  out  2  port address. 00 = status, 01 = LED data, 10 = switch low, 11 = switch high.
- pWriteData  out  12  write data.
- pReadData  in  32  read data, combinational from the responder (valid in the same cycle as pRead/addr).

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - busy, done, err, pRead, pWrite, addr, pWriteData, result all 0.
  - Operand registers a, b, op_r and the poll counter are cleared.
  - Reset mid-operation aborts immediately, with no further bus strobes from the next cycle.
- Bus outputs are Moore-decoded from state only.
  - pRead and pWrite are never both 1.
  - In any state with no strobe, addr=00 and pWriteData=0.
- States, one cycle each unless noted:
  - IDLE: no strobes. start==1 → latch op_r<=op, clear err and the poll counter → WAIT_IN.
  - WAIT_IN (multi-cycle): pRead=1, addr=00. pReadData[1]==1 → RD_HI; otherwise stay. Status bit 1 is sticky in the responder, so after the first input, later operations pass through WAIT_IN in 1 cycle.
  - RD_HI: pRead=1, addr=11. a<=pReadData[7:0] → RD_LO.
  - RD_LO: pRead=1, addr=10. b<=pReadData[7:0] → CALC.
  - CALC: result register <= f(op_r,a,b), truncated to 12 bits.
    - add: zero-extended 9-bit sum.
    - sub: 12-bit two's-complement wrap, e.g. 0x01-0x02 = 0xFFF.
    - mul: low 12 bits of the 16-bit product.
    - 11: concatenation {a[3:0],b}.
    - Then clear the poll counter → WR_LED.
  - WR_LED: pWrite=1, addr=01, pWriteData=result. Exactly one cycle → WAIT_ACK.
  - WAIT_ACK (multi-cycle): pRead=1, addr=00. pReadData[0]==1 → DONE; otherwise stay. The responder clears status[0] on the write edge, so the first WAIT_ACK cycle reads 0 unless the display button is held.
  - DONE: done=1 for one cycle → IDLE.
- Latency with status bits already set: start accepted at edge N; pWrite high in cycle N+4; done high in cycle N+6.
- start asserted while busy is ignored (not queued).
- Start asserted in the same cycle as DONE's exit is not accepted, because acceptance happens only in IDLE.
- result holds its value until the next CALC.
- pReadData[31:8] is ignored.

Optional Feature:
- Macro: IO_MASTER_TIMEOUT_EN.
- Defined:
  - The poll counter increments on each cycle spent in WAIT_IN or WAIT_ACK without the awaited bit.
  - On reaching POLL_LIMIT-1 it sets err=1 and moves to DONE (done pulses).
  - A timeout in WAIT_IN skips the reads, the calculation and the write.
  - err stays 1 until the next accepted start or reset.
- Undefined: no counter logic, err tied to 0, and the wait states wait indefinitely.

Test Plan:
- Reset, then start with op=00, responder status=2'b10, switch=0x1234 → reads at addr 00, 11, 10 in consecutive cycles; pWrite with addr=01, pWriteData=0x046; done after status[0] goes high; result=0x046.
- op=01, switch=0x0102 → pWriteData=0xFFF. op=10, switch=0xFFFF → pWriteData=0xE01 (0xFE01 truncated). op=11, switch=0xA5C3 → pWriteData=0x5C3.
- Status held at 0 for 50 cycles, then bit 1 set → pRead/addr=00 held for all 50 cycles, no other strobes, RD_HI in the cycle after bit 1 is observed.
- start pulsed again in WAIT_ACK and in DONE → ignored; exactly one pWrite per accepted start.
- reset=0 asserted in WAIT_ACK → the next cycle is IDLE with all outputs 0; a following start runs a full operation normally.
- With IO_MASTER_TIMEOUT_EN and POLL_LIMIT=8, status stuck at 0 → done and err=1 after 8 WAIT_IN cycles, no reads at 11/10, no pWrite; the next start clears err.
